// File: rtl/pong_game_ctrl_if.sv
// Pong controller I/O bundle: button/frame/ball-event inputs and game status outputs.
// master drives the inputs (graphics datapath / test), slave is the controller.
interface pong_game_ctrl_if;
  logic [3:0] btn;
  logic       frame_tick;
  logic       l_hit;
  logic       l_mis;
  logic       r_hit;
  logic       r_mis;
  logic       gra_still;
  logic [3:0] l_score;
  logic [3:0] r_score;
  logic [7:0] rally;
  logic       game_over;
  logic       winner;
  logic [1:0] state;

  modport master (
    output btn, frame_tick, l_hit, l_mis, r_hit, r_mis,
    input  gra_still, l_score, r_score, rally, game_over, winner, state
  );

  modport slave (
    input  btn, frame_tick, l_hit, l_mis, r_hit, r_mis,
    output gra_still, l_score, r_score, rally, game_over, winner, state
  );
endinterface

// File: rtl/pong_game_ctrl.sv
// Pong game FSM: scoring, rally count, serve hold timer; all outputs registered, one-cycle updates.
// Define PONG_AUTOSERVE_EN to serve automatically when the hold timer expires (default: wait for press).
module pong_game_ctrl #(
  parameter int WIN_SCORE    = 7,
  parameter int SERVE_FRAMES = 120
) (
  input logic             clk,
  input logic             reset,
  pong_game_ctrl_if.slave io
);

  typedef enum logic [1:0] {
    S_NEWGAME = 2'b00,
    S_PLAY    = 2'b01,
    S_NEWBALL = 2'b10,
    S_OVER    = 2'b11
  } state_t;

  state_t     st;
  logic [3:0] btn_q;
  logic [7:0] timer;
  logic [3:0] l_score;
  logic [3:0] r_score;
  logic [7:0] rally;
  logic       gra_still;
  logic       game_over;
  logic       winner;

  logic       press;
  logic [3:0] l_next;
  logic [3:0] r_next;
  logic [7:0] timer_nxt;

  assign press     = |(io.btn & ~btn_q);
  assign l_next    = l_score + 4'd1;
  assign r_next    = r_score + 4'd1;
  // Hold timer counts frames down and parks at zero.
  assign timer_nxt = (io.frame_tick && timer != 8'd0) ? timer - 8'd1 : timer;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      st        <= S_NEWGAME;
      btn_q     <= 4'd0;
      timer     <= 8'd0;
      l_score   <= 4'd0;
      r_score   <= 4'd0;
      rally     <= 8'd0;
      gra_still <= 1'b1;
      game_over <= 1'b0;
      winner    <= 1'b0;
    end else begin
      btn_q <= io.btn;
      case (st)
        S_NEWGAME: begin
          if (press) begin
            st        <= S_PLAY;
            gra_still <= 1'b0;
          end
        end
        S_PLAY: begin
          // A left miss wins over a simultaneous right miss; any miss masks hits.
          if (io.l_mis) begin
            r_score   <= r_next;
            rally     <= 8'd0;
            timer     <= 8'(SERVE_FRAMES);
            gra_still <= 1'b1;
            if (r_next == 4'(WIN_SCORE)) begin
              st        <= S_OVER;
              game_over <= 1'b1;
              winner    <= 1'b1;
            end else begin
              st <= S_NEWBALL;
            end
          end else if (io.r_mis) begin
            l_score   <= l_next;
            rally     <= 8'd0;
            timer     <= 8'(SERVE_FRAMES);
            gra_still <= 1'b1;
            if (l_next == 4'(WIN_SCORE)) begin
              st        <= S_OVER;
              game_over <= 1'b1;
              winner    <= 1'b0;
            end else begin
              st <= S_NEWBALL;
            end
          end else if ((io.l_hit || io.r_hit) && rally != 8'hFF) begin
            rally <= rally + 8'd1;
          end
        end
        S_NEWBALL: begin
          timer <= timer_nxt;
`ifdef PONG_AUTOSERVE_EN
          if (timer_nxt == 8'd0) begin
            st        <= S_PLAY;
            gra_still <= 1'b0;
          end
`else
          if (press && timer == 8'd0) begin
            st        <= S_PLAY;
            gra_still <= 1'b0;
          end
`endif
        end
        S_OVER: begin
          timer <= timer_nxt;
          if (press && timer == 8'd0) begin
            st        <= S_NEWGAME;
            game_over <= 1'b0;
            l_score   <= 4'd0;
            r_score   <= 4'd0;
          end
        end
        default: st <= S_NEWGAME;
      endcase
    end
  end

  assign io.state     = st;
  assign io.gra_still = gra_still;
  assign io.l_score   = l_score;
  assign io.r_score   = r_score;
  assign io.rally     = rally;
  assign io.game_over = game_over;
  assign io.winner    = winner;

endmodule

// File: doc/pong_game_ctrl.md
PONG_GAME_CTRL -- requirements
Module: pong_game_ctrl

Interface
REQ-001 SHALL have parameter WIN_SCORE, default 7, meaning the score that ends the game (legal range 1..15).
REQ-002 SHALL have parameter SERVE_FRAMES, default 120, meaning the frame ticks of hold before a serve is allowed (legal range 1..255).
REQ-003 SHALL have port clk, input, 1 bit: system clock, all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port btn, input, 4 bits: player buttons, any bit counts as "press".
REQ-006 SHALL have port frame_tick, input, 1 bit: one-cycle pulse per video frame.
REQ-007 SHALL have ports l_hit, l_mis, r_hit and r_mis, inputs, 1 bit each: ball events from the graphics datapath.
REQ-008 SHALL have port gra_still, output, 1 bit: freezes and recentres the ball when 1.
REQ-009 SHALL have ports l_score and r_score, outputs, 4 bits each: binary scores.
REQ-010 SHALL have port rally, output, 8 bits: count of paddle hits in the current rally.
REQ-011 SHALL have port game_over, output, 1 bit: high in state OVER.
REQ-012 SHALL have port winner, output, 1 bit: 0 = left, 1 = right; valid while game_over = 1.
REQ-013 SHALL have port state, output, 2 bits: NEWGAME=00, PLAY=01, NEWBALL=10, OVER=11.

Function
REQ-014 SHALL register btn once and define press = |(btn & ~btn_q), a one-cycle rising-edge pulse; a held button SHALL NOT re-trigger.
REQ-015 In NEWGAME: gra_still=1, scores and rally held at 0; press -> PLAY.
REQ-016 In PLAY: gra_still=0; l_hit or r_hit SHALL increment rally, saturating at 255.
REQ-017 In PLAY, l_mis SHALL increment r_score and r_mis SHALL increment l_score, on the same edge.
REQ-018 If l_mis and r_mis are both high in one cycle, only l_mis SHALL be acted on.
REQ-019 On a miss, if the incremented score equals WIN_SCORE, the block SHALL go to OVER and set winner to the scoring side; otherwise it SHALL go to NEWBALL.
REQ-020 On either transition in REQ-019, the block SHALL clear rally and load the serve timer with SERVE_FRAMES.
REQ-021 In PLAY, hit and miss on the same cycle: the miss SHALL take effect and the hit SHALL be ignored.
REQ-022 In NEWBALL and OVER: gra_still=1; the timer SHALL decrement on each frame_tick, stop at 0 and never wrap.
REQ-023 In NEWBALL, leaving for PLAY SHALL follow the Configuration section (REQ-029/REQ-030).
REQ-024 In OVER, timer == 0 and press -> NEWGAME, and scores SHALL clear on that edge; a press while the timer is non-zero SHALL be ignored.
REQ-025 Ball events outside PLAY SHALL be ignored.
REQ-026 Outputs SHALL be registered or decoded from registered state only, with no combinational path from inputs to outputs.
REQ-027 State changes SHALL take one cycle: an event at edge N gives the new outputs after edge N.

Reset
REQ-028 While reset = 0, the block SHALL hold: state=NEWGAME, gra_still=1, l_score=0, r_score=0, rally=0, game_over=0, winner=0, timer=0, btn_q=0.
- Assertion mid-operation SHALL force these values immediately.
- Deassertion SHALL resume in NEWGAME, with the first press needing a fresh edge.

Configuration
REQ-029 With macro PONG_AUTOSERVE_EN defined, NEWBALL SHALL go to PLAY on the cycle the timer reaches 0, with no press needed; press SHALL be ignored in NEWBALL.
REQ-030 Without PONG_AUTOSERVE_EN, NEWBALL SHALL go to PLAY only on press with timer == 0; the block SHALL wait indefinitely otherwise.
- The OVER behaviour in REQ-024 is unaffected by the macro.

Verification
REQ-031 Reset, then btn=0001 for 1 cycle -> state 00->01 next cycle, gra_still 1->0; holding btn gives no further transition.
REQ-032 PLAY, l_hit pulsed 3 times then r_mis -> rally 3 then 0, l_score=1, state=10, timer=120; after 120 frame_ticks plus a press -> state=01.
- With PONG_AUTOSERVE_EN: state=01 after the 120th tick, no press needed.
REQ-033 PLAY with l_score=6, then r_mis -> l_score=7, state=11, game_over=1, winner=0; a press before 120 ticks is ignored; a press after -> state=00 with scores 0.
REQ-034 Same-cycle l_mis+r_mis+r_hit with scores 2/2 -> r_score=3, l_score=2, rally=0, state=10.
REQ-035 rally preset by 300 hits -> rally stays 255; reset asserted in NEWBALL mid-count -> all outputs at reset values asynchronously, before the next clk edge.
